// File: rtl/display_scan_driver_pkg.sv
// Shared types and segment decode for the six-digit scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam seg_t SEG_DASH   = 7'h3F;
  localparam int   NUM_DIGITS = 6;

  function automatic seg_t bcd_to_seg(input logic [3:0] d);
    seg_t s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_driver_tick_divider.sv
// Free-running prescaler; tick is high for the one cycle
// in which the count sits at DIV-1.
module tick_divider #(
  parameter int DIV = 8333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Six-digit multiplexed 7-segment driver with per-frame
// snapshot, group blinking and a blinking colon.
import disp_pkg::*;

module display_scan_driver #(
  parameter int SCAN_DIV      = 8333,
  parameter int BLINK_TICKS   = 3000,
  parameter int BLANK_HOUR_LZ = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hour_tens,
  input  logic [3:0] hour_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_units,
  input  logic [2:0] blink_mask,
  input  logic       colon_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

  logic          tick;
  digit_idx_t    idx;
  digit_idx_t    idx_nx;
  logic [BW-1:0] blink_cnt;
  logic          blink_state;
  logic          blink_wrap;
  logic          blink_nx;
  logic          grp_blink;
  logic [3:0]    digit;
  logic [3:0]    live [NUM_DIGITS];
  logic [3:0]    snap [NUM_DIGITS];
  seg_t          seg_nx;
  logic          dp_nx;
  logic [5:0]    an_nx;

  tick_divider #(
    .DIV(SCAN_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign live[0] = hour_tens;
  assign live[1] = hour_units;
  assign live[2] = min_tens;
  assign live[3] = min_units;
  assign live[4] = sec_tens;
  assign live[5] = sec_units;

  always_comb begin
    idx_nx     = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    blink_wrap = (blink_cnt == BW'(BLINK_TICKS - 1));
    blink_nx   = blink_state ^ blink_wrap;
    digit      = (idx_nx == 3'd0) ? live[0] : snap[idx_nx];
    case (idx_nx)
      3'd0, 3'd1: grp_blink = blink_mask[2];
      3'd2, 3'd3: grp_blink = blink_mask[1];
      default:    grp_blink = blink_mask[0];
    endcase
    // blinking group wins over leading-zero blanking
    if (grp_blink && blink_nx) begin
      seg_nx = SEG_BLANK;
    end else if (BLANK_HOUR_LZ != 0 && idx_nx == 3'd0 && digit == 4'd0) begin
      seg_nx = SEG_BLANK;
    end else begin
      seg_nx = bcd_to_seg(digit);
    end
    dp_nx = !((idx_nx == 3'd1 || idx_nx == 3'd3) && colon_en && !blink_nx);
    an_nx = ~(6'b1 << idx_nx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 3'd5;
      blink_cnt   <= '0;
      blink_state <= 1'b0;
      an_n        <= 6'h3F;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
    end else if (tick) begin
      idx         <= idx_nx;
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
      blink_state <= blink_nx;
      an_n        <= an_nx;
      seg_n       <= seg_nx;
      dp_n        <= dp_nx;
      if (idx_nx == 3'd0) begin
        for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= live[i];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized scoreboard bench: a tick-level reference model queues
// expected frames, a monitor pops them whenever the anode strobe moves.
module tb_display_scan_driver;

  localparam int SD = 4;
  localparam int BT = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dig [6];
  logic [2:0] blink_mask = 3'b000;
  logic       colon_en = 1'b1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [5:0] an0, an1;

  typedef struct {
    logic [5:0] an;
    logic [6:0] s0;
    logic [6:0] s1;
    logic       dp;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  logic [6:0] segtab [10];

  always #5 clk = ~clk;

  display_scan_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT), .BLANK_HOUR_LZ(0)) dut0 (
    .clk(clk), .reset(reset),
    .hour_tens(dig[0]), .hour_units(dig[1]), .min_tens(dig[2]),
    .min_units(dig[3]), .sec_tens(dig[4]), .sec_units(dig[5]),
    .blink_mask(blink_mask), .colon_en(colon_en),
    .seg_n(seg0), .dp_n(dp0), .an_n(an0)
  );

  display_scan_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT), .BLANK_HOUR_LZ(1)) dut1 (
    .clk(clk), .reset(reset),
    .hour_tens(dig[0]), .hour_units(dig[1]), .min_tens(dig[2]),
    .min_units(dig[3]), .sec_tens(dig[4]), .sec_units(dig[5]),
    .blink_mask(blink_mask), .colon_en(colon_en),
    .seg_n(seg1), .dp_n(dp1), .an_n(an1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from the tick number since release.
  int n_edges = 0;
  logic [3:0] frame [6];
  always @(posedge clk) begin
    if (!reset) begin
      n_edges = 0;
    end else begin
      n_edges++;
      if (n_edges % SD == 0) begin
        int k, pos, bs, d, lz_blank;
        logic blanked;
        exp_t e;
        k   = n_edges / SD;
        pos = (k - 1) % 6;
        bs  = (k / BT) % 2;
        if (pos == 0) for (int i = 0; i < 6; i++) frame[i] = dig[i];
        d = int'(pos == 0 ? dig[0] : frame[pos]);
        blanked  = blink_mask[2 - pos / 2] && bs == 1;
        lz_blank = (pos == 0 && d == 0) ? 1 : 0;
        e.an = ~(6'b1 << pos);
        e.s0 = blanked ? 7'h7F : (d > 9 ? 7'h3F : segtab[d]);
        e.s1 = (blanked || lz_blank == 1) ? 7'h7F : e.s0;
        e.dp = ((pos == 1 || pos == 3) && colon_en && bs == 0) ? 1'b0 : 1'b1;
        exp_q.push_back(e);
      end
    end
  end

  logic [5:0] prev_an = 6'h3F;
  int idle = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("rst_an", {2'b0, an0}, 8'h3F);
      chk("rst_seg", {1'b0, seg0}, 8'h7F);
      chk("rst_dp", {7'b0, dp0}, 8'h01);
      prev_an = 6'h3F;
      idle = 0;
    end else if (an0 !== prev_an) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: an_n %h with empty queue", an0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("an_n", {2'b0, an0}, {2'b0, e.an});
        chk("an_n_lz", {2'b0, an1}, {2'b0, e.an});
        chk("seg_n", {1'b0, seg0}, {1'b0, e.s0});
        chk("seg_n_lz", {1'b0, seg1}, {1'b0, e.s1});
        chk("dp_n", {7'b0, dp0}, {7'b0, e.dp});
      end
      prev_an = an0;
      idle = 0;
    end else begin
      idle++;
      if (idle > SD) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout: an_n stuck at %h for %0d cycles", an0, idle);
        idle = 0;
      end
    end
  end

  task automatic set_digits(input int a, b, c, d, e, f);
    dig[0] = 4'(a); dig[1] = 4'(b); dig[2] = 4'(c);
    dig[3] = 4'(d); dig[4] = 4'(e); dig[5] = 4'(f);
  endtask

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    set_digits(2, 3, 5, 9, 4, 7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    // early hold: no strobe before the first tick
    repeat (3) @(negedge clk);
    chk("hold_an", {2'b0, an0}, 8'h3F);
    // two frames, then tear during digit 2 of the third frame
    repeat (SD * 12 + SD * 2 + 1) @(negedge clk);
    dig[3] = 4'd0;
    dig[4] = 4'd0;
    repeat (SD * 10) @(negedge clk);
    // blink on minutes, then invalid BCD and zero hour tens
    blink_mask = 3'b010;
    repeat (SD * 14) @(negedge clk);
    blink_mask = 3'b000;
    set_digits(0, 1, 2, 3, 4, 12);
    repeat (SD * 14) @(negedge clk);
    // randomized phase with one mid-frame reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) dig[$urandom_range(5)] = 4'($urandom_range(11));
      if ($urandom_range(40) == 0) blink_mask = 3'($urandom);
      if ($urandom_range(40) == 0) colon_en = 1'($urandom);
      if (c == 1500) begin
        while (an0 !== 6'b110111) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_an", {2'b0, an0}, 8'h3F);
        chk("mid_rst_seg", {1'b0, seg0}, 8'h7F);
        @(negedge clk);
        reset = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 8'(exp_q.size() > 1), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
